// File: rtl/cache_controller_gen2.sv
// Set-associative cache control FSM: burst line fill/writeback, write-back or write-through
// policy, full-cache flush walk and hmem timeout abort. Strobes drive the tag/data/LRU datapath.
module cache_controller_gen2 #(
  parameter int unsigned WordsPerLine  = 4,
  parameter int unsigned NumSets       = 16,
  parameter int unsigned NumWays       = 2,
  parameter bit          WriteThrough  = 1'b0,
  parameter int unsigned TimeoutCycles = 64,
  localparam int unsigned WordW = (WordsPerLine > 1) ? $clog2(WordsPerLine) : 1,
  localparam int unsigned WalkW = (NumSets * NumWays > 1) ? $clog2(NumSets * NumWays) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  input  logic [1:0]       req_operation_i,
  output logic             req_fulfilled_o,
  output logic             req_error_o,
  output logic             hmem_req_valid_o,
  output logic [1:0]       hmem_req_operation_o,
  input  logic             hmem_req_fulfilled_i,
  output logic [WordW-1:0] word_index_o,
  input  logic             valid_block_match_i,
  input  logic             valid_dirty_bit_i,
  output logic             walk_active_o,
  output logic [WalkW-1:0] walk_index_o,
  output logic             perform_write_o,
  output logic             set_selected_dirty_bit_o,
  output logic             clear_selected_dirty_bit_o,
  output logic             clear_selected_valid_bit_o,
  output logic             finish_new_line_install_o,
  output logic             set_hmem_block_address_o,
  output logic             use_victim_tag_for_hmem_block_address_o,
  output logic             process_lru_counters_o,
  output logic             miss_recovery_mode_o,
  output logic             count_hit_o,
  output logic             count_miss_o,
  output logic             count_read_o,
  output logic             count_write_o
);

  localparam int unsigned Lines = NumSets * NumWays;
  localparam int unsigned ToW   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  localparam logic [1:0] OpLoad     = 2'b00;
  localparam logic [1:0] OpStore    = 2'b01;
  localparam logic [1:0] OpClflush  = 2'b10;
  localparam logic [1:0] OpFlushAll = 2'b11;

  localparam logic [WordW-1:0] LastWord = WordW'(WordsPerLine - 1);
  localparam logic [WalkW-1:0] LastLine = WalkW'(Lines - 1);
  localparam logic [ToW-1:0]   ToLast   = (TimeoutCycles > 0) ? ToW'(TimeoutCycles - 1) : '0;

  typedef enum logic [2:0] {
    StIdle,
    StWriteback,
    StAllocate,
    StFlush,
    StWtStore,
    StWalkCheck,
    StWalkWb
  } state_e;

  state_e           state_q, state_d, prev_state_q;
  logic [WordW-1:0] word_q, word_d;
  logic [WalkW-1:0] walk_q, walk_d;
  logic [ToW-1:0]   to_q, to_d;

  logic hmem_active, in_burst, stalled, timeout, beat_last, walk_adv;

  assign hmem_active = state_q inside {StWriteback, StAllocate, StFlush, StWtStore, StWalkWb};
  assign in_burst    = state_q inside {StWriteback, StAllocate, StFlush, StWalkWb};
  assign stalled     = hmem_active && !hmem_req_fulfilled_i;
  assign timeout     = (TimeoutCycles != 0) && stalled && (to_q == ToLast);
  assign beat_last   = hmem_req_fulfilled_i && (word_q == LastWord);

  assign word_index_o = word_q;
  assign walk_index_o = walk_q;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    walk_d   = walk_q;
    walk_adv = 1'b0;

    req_fulfilled_o                         = 1'b0;
    req_error_o                             = 1'b0;
    hmem_req_valid_o                        = 1'b0;
    hmem_req_operation_o                    = OpLoad;
    walk_active_o                           = 1'b0;
    perform_write_o                         = 1'b0;
    set_selected_dirty_bit_o                = 1'b0;
    clear_selected_dirty_bit_o              = 1'b0;
    clear_selected_valid_bit_o              = 1'b0;
    finish_new_line_install_o               = 1'b0;
    set_hmem_block_address_o                = 1'b0;
    use_victim_tag_for_hmem_block_address_o = 1'b0;
    process_lru_counters_o                  = 1'b0;
    miss_recovery_mode_o                    = 1'b0;
    count_hit_o                             = 1'b0;
    count_miss_o                            = 1'b0;
    count_read_o                            = 1'b0;
    count_write_o                           = 1'b0;

    // Outputs stay quiet for the whole reset pulse, even with a request held on the port.
    if (!reset_i) begin
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            unique case (req_operation_i)
              OpLoad, OpStore: begin
                if (valid_block_match_i) begin
                  // The re-lookup after a fill is not a genuine hit.
                  count_hit_o   = (prev_state_q != StAllocate);
                  count_read_o  = (req_operation_i == OpLoad);
                  count_write_o = (req_operation_i == OpStore);
                  if (req_operation_i == OpStore) begin
                    perform_write_o = 1'b1;
                    if (WriteThrough) begin
                      state_d = StWtStore;
                    end else begin
                      set_selected_dirty_bit_o = 1'b1;
                      req_fulfilled_o          = 1'b1;
                      process_lru_counters_o   = 1'b1;
                    end
                  end else begin
                    req_fulfilled_o        = 1'b1;
                    process_lru_counters_o = 1'b1;
                  end
                end else begin
                  count_miss_o             = 1'b1;
                  set_hmem_block_address_o = 1'b1;
                  if (valid_dirty_bit_i) begin
                    use_victim_tag_for_hmem_block_address_o = 1'b1;
                    state_d                                 = StWriteback;
                  end else begin
                    state_d = StAllocate;
                  end
                end
              end
              OpClflush: begin
                if (!valid_block_match_i) begin
                  req_fulfilled_o = 1'b1;
                end else if (!valid_dirty_bit_i) begin
                  clear_selected_valid_bit_o = 1'b1;
                  req_fulfilled_o            = 1'b1;
                end else begin
                  set_hmem_block_address_o                = 1'b1;
                  use_victim_tag_for_hmem_block_address_o = 1'b1;
                  state_d                                 = StFlush;
                end
              end
              OpFlushAll: begin
                walk_d  = '0;
                state_d = StWalkCheck;
              end
            endcase
          end
        end
        StWriteback: begin
          hmem_req_valid_o     = 1'b1;
          hmem_req_operation_o = OpStore;
          if (beat_last) begin
            clear_selected_dirty_bit_o = 1'b1;
            clear_selected_valid_bit_o = 1'b1;
            set_hmem_block_address_o   = 1'b1;
            state_d                    = StAllocate;
          end
        end
        StAllocate: begin
          hmem_req_valid_o     = 1'b1;
          perform_write_o      = 1'b1;
          miss_recovery_mode_o = 1'b1;
          if (beat_last) begin
            finish_new_line_install_o  = 1'b1;
            clear_selected_dirty_bit_o = 1'b1;
            process_lru_counters_o     = 1'b1;
            state_d                    = StIdle;
          end
        end
        StFlush: begin
          hmem_req_valid_o     = 1'b1;
          hmem_req_operation_o = OpStore;
          if (beat_last) begin
            clear_selected_dirty_bit_o = 1'b1;
            clear_selected_valid_bit_o = 1'b1;
            req_fulfilled_o            = 1'b1;
            state_d                    = StIdle;
          end
        end
        StWtStore: begin
          hmem_req_valid_o     = 1'b1;
          hmem_req_operation_o = OpStore;
          if (hmem_req_fulfilled_i) begin
            req_fulfilled_o        = 1'b1;
            process_lru_counters_o = 1'b1;
            state_d                = StIdle;
          end
        end
        StWalkCheck: begin
          walk_active_o = 1'b1;
          if (valid_dirty_bit_i) begin
            state_d = StWalkWb;
          end else begin
            clear_selected_valid_bit_o = 1'b1;
            walk_adv                   = 1'b1;
          end
        end
        StWalkWb: begin
          walk_active_o        = 1'b1;
          hmem_req_valid_o     = 1'b1;
          hmem_req_operation_o = OpStore;
          if (beat_last) begin
            clear_selected_dirty_bit_o = 1'b1;
            clear_selected_valid_bit_o = 1'b1;
            walk_adv                   = 1'b1;
          end
        end
        default: begin
          state_d                                 = state_e'(3'bxxx);
          req_fulfilled_o                         = 1'bx;
          req_error_o                             = 1'bx;
          hmem_req_valid_o                        = 1'bx;
          hmem_req_operation_o                    = 2'bxx;
          walk_active_o                           = 1'bx;
          perform_write_o                         = 1'bx;
          set_selected_dirty_bit_o                = 1'bx;
          clear_selected_dirty_bit_o              = 1'bx;
          clear_selected_valid_bit_o              = 1'bx;
          finish_new_line_install_o               = 1'bx;
          set_hmem_block_address_o                = 1'bx;
          use_victim_tag_for_hmem_block_address_o = 1'bx;
          process_lru_counters_o                  = 1'bx;
          miss_recovery_mode_o                    = 1'bx;
          count_hit_o                             = 1'bx;
          count_miss_o                            = 1'bx;
          count_read_o                            = 1'bx;
          count_write_o                           = 1'bx;
        end
      endcase

      if (walk_adv) begin
        if (walk_q == LastLine) begin
          req_fulfilled_o = 1'b1;
          walk_d          = '0;
          state_d         = StIdle;
        end else begin
          walk_d  = walk_q + 1'b1;
          state_d = StWalkCheck;
        end
      end

      if (in_burst && hmem_req_fulfilled_i) begin
        word_d = beat_last ? '0 : word_q + 1'b1;
      end

      // Abort: the selected line is dropped rather than retried.
      if (timeout) begin
        req_fulfilled_o            = 1'b1;
        req_error_o                = 1'b1;
        clear_selected_valid_bit_o = 1'b1;
        if (state_q == StAllocate) clear_selected_dirty_bit_o = 1'b1;
        word_d  = '0;
        walk_d  = '0;
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    to_d = '0;
    if (stalled && (state_d == state_q)) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      prev_state_q <= StIdle;
      word_q       <= '0;
      walk_q       <= '0;
      to_q         <= '0;
    end else begin
      state_q      <= state_d;
      prev_state_q <= state_q;
      word_q       <= word_d;
      walk_q       <= walk_d;
      to_q         <= to_d;
    end
  end

endmodule
